// File: rtl/decode_pkg.sv
// Shared RV32I decode types: instruction formats, base opcodes and the
// per-opcode control classification used by the decode stage.
package decode_pkg;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
  } instr_fmt_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    instr_fmt_t fmt;
    logic       rs1_en;
    logic       rs2_en;
    logic       rd_we;
    logic       illegal;
  } decoded_t;

  // Illegal encodings get every enable cleared so nothing downstream acts on them.
  function automatic decoded_t classify(input logic [6:0] op, input logic rd_nz);
    decoded_t d;
    d = '{fmt: FMT_X, rs1_en: 1'b0, rs2_en: 1'b0, rd_we: 1'b0, illegal: 1'b1};
    if (op[1:0] == 2'b11) begin
      case (op)
        OP_REG:                              d.fmt = FMT_R;
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: d.fmt = FMT_I;
        OP_STORE:                            d.fmt = FMT_S;
        OP_BRANCH:                           d.fmt = FMT_B;
        OP_LUI, OP_AUIPC:                    d.fmt = FMT_U;
        OP_JAL:                              d.fmt = FMT_J;
        default:                             d.fmt = FMT_X;
      endcase
    end
    if (d.fmt != FMT_X) begin
      d.illegal = 1'b0;
      d.rs1_en  = d.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
      d.rs2_en  = d.fmt inside {FMT_R, FMT_S, FMT_B};
      d.rd_we   = (d.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && rd_nz;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: assembles the format-specific
// immediate and sign-extends it from bit 31 to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  instr_fmt_t      fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    case (fmt)
      FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   raw = {instr[31:12], 12'b0};
      FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: raw = '0;
    endcase
    imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: one output register with valid/ready flow
// control, flush, and a saturating count of illegal instructions drained.
module decode_stage
  import decode_pkg::*;
#(
  parameter int ADD_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int XLEN       = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic [XLEN-1:0]       pc_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       pc_out,
  output logic [6:0]            opcode,
  output logic [2:0]            func3,
  output logic [6:0]            func7,
  output logic [ADD_WIDTH-1:0]  add_rs1,
  output logic [ADD_WIDTH-1:0]  add_rs2,
  output logic [ADD_WIDTH-1:0]  add_rd,
  output logic [XLEN-1:0]       imm,
  output instr_fmt_t            fmt,
  output logic                  rs1_en,
  output logic                  rs2_en,
  output logic                  rd_we,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  illegal_cnt
);

  decoded_t        dec;
  logic [XLEN-1:0] imm_next;
  logic            accept;

  assign dec      = classify(instr_in[6:0], instr_in[11:7] != 5'd0);
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr_in[31:0]),
    .fmt   (dec.fmt),
    .imm   (imm_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      pc_out      <= '0;
      opcode      <= '0;
      func3       <= '0;
      func7       <= '0;
      add_rs1     <= '0;
      add_rs2     <= '0;
      add_rd      <= '0;
      imm         <= '0;
      fmt         <= FMT_X;
      rs1_en      <= 1'b0;
      rs2_en      <= 1'b0;
      rd_we       <= 1'b0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      // Count only illegal instructions actually handed downstream.
      if (out_valid && out_ready && illegal && !flush && illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + CNT_WIDTH'(1);

      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        pc_out    <= pc_in;
        opcode    <= instr_in[6:0];
        func3     <= instr_in[14:12];
        func7     <= instr_in[31:25];
        add_rs1   <= ADD_WIDTH'(instr_in[19:15]);
        add_rs2   <= ADD_WIDTH'(instr_in[24:20]);
        add_rd    <= ADD_WIDTH'(instr_in[11:7]);
        imm       <= imm_next;
        fmt       <= dec.fmt;
        rs1_en    <= dec.rs1_en;
        rs2_en    <= dec.rs2_en;
        rd_we     <= dec.rd_we;
        illegal   <= dec.illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized traffic
// compared against a cycle-level behavioural model of the stage.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int CW     = 2;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   instr_in, pc_in, pc_out, imm;
  logic [6:0]    opcode, func7;
  logic [2:0]    func3;
  logic [4:0]    add_rs1, add_rs2, add_rd;
  instr_fmt_t    fmt;
  logic          rs1_en, rs2_en, rd_we, illegal;
  logic [CW-1:0] illegal_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  logic        m_known = 1'b0;
  logic        m_valid, m_zero;
  logic [31:0] m_instr, m_pc;
  int          m_cnt;
  logic        last_in_ready;

  always #5 clk = ~clk;

  decode_stage #(
    .ADD_WIDTH (5),
    .DATA_WIDTH(32),
    .XLEN      (32),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr_in   (instr_in),
    .pc_in      (pc_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pc_out     (pc_out),
    .opcode     (opcode),
    .func3      (func3),
    .func7      (func7),
    .add_rs1    (add_rs1),
    .add_rs2    (add_rs2),
    .add_rd     (add_rd),
    .imm        (imm),
    .fmt        (fmt),
    .rs1_en     (rs1_en),
    .rs2_en     (rs2_en),
    .rd_we      (rd_we),
    .illegal    (illegal),
    .illegal_cnt(illegal_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_fmt_t ref_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h33:                      return FMT_R;
      7'h13, 7'h03, 7'h67, 7'h73: return FMT_I;
      7'h23:                      return FMT_S;
      7'h63:                      return FMT_B;
      7'h37, 7'h17:               return FMT_U;
      7'h6F:                      return FMT_J;
      default:                    return FMT_X;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic signed [31:0] s;
    s = i;
    case (ref_fmt(i))
      FMT_I: return 32'(s >>> 20);
      FMT_S: return (32'(s >>> 25) << 5) | 32'(i[11:7]);
      FMT_B: return (32'(s >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      FMT_U: return i & 32'hFFFFF000;
      FMT_J: return (32'(s >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_fields(input logic [31:0] i, input logic [31:0] pc);
    instr_fmt_t f;
    f = ref_fmt(i);
    check("pc_out",  pc_out,  pc);
    check("opcode",  opcode,  i[6:0]);
    check("func3",   func3,   i[14:12]);
    check("func7",   func7,   i[31:25]);
    check("add_rs1", add_rs1, i[19:15]);
    check("add_rs2", add_rs2, i[24:20]);
    check("add_rd",  add_rd,  i[11:7]);
    check("imm",     imm,     ref_imm(i));
    check("fmt",     fmt,     f);
    check("illegal", illegal, f == FMT_X);
    check("rs1_en",  rs1_en,  f inside {FMT_R, FMT_I, FMT_S, FMT_B});
    check("rs2_en",  rs2_en,  f inside {FMT_R, FMT_S, FMT_B});
    check("rd_we",   rd_we,   (f inside {FMT_R, FMT_I, FMT_U, FMT_J}) && i[11:7] != 5'd0);
  endtask

  task automatic check_reset_fields();
    check("rst_pc",   pc_out, 0);
    check("rst_bits", {opcode, func3, func7, add_rs1, add_rs2, add_rd}, 0);
    check("rst_imm",  imm, 0);
    check("rst_fmt",  fmt, FMT_X);
    check("rst_ctl",  {rs1_en, rs2_en, rd_we, illegal}, 0);
  endtask

  task automatic compare_all();
    if (!m_known) return;
    check("in_ready",    in_ready,    !flush && (!m_valid || out_ready));
    check("out_valid",   out_valid,   m_valid);
    check("illegal_cnt", illegal_cnt, m_cnt);
    if (m_valid) check_fields(m_instr, m_pc);
    else if (m_zero) check_reset_fields();
  endtask

  task automatic step_model();
    logic rdy;
    if (rst) begin
      m_known = 1'b1; m_valid = 1'b0; m_zero = 1'b1; m_cnt = 0;
    end else if (m_known) begin
      rdy = !flush && (!m_valid || out_ready);
      if (m_valid && out_ready && !flush && ref_fmt(m_instr) == FMT_X && m_cnt < CNTMAX)
        m_cnt++;
      if (flush) m_valid = 1'b0;
      else if (in_valid && rdy) begin
        m_valid = 1'b1; m_instr = instr_in; m_pc = pc_in; m_zero = 1'b0;
      end else if (out_ready) m_valid = 1'b0;
    end
  endtask

  task automatic cyc(input logic r, input logic fl, input logic iv, input logic ordy,
                     input logic [31:0] ins, input logic [31:0] pc);
    rst = r; flush = fl; in_valid = iv; out_ready = ordy; instr_in = ins; pc_in = pc;
    #1;
    last_in_ready = in_ready;
    compare_all();
    step_model();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr_in = '0; pc_in = '0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // basic formats
    cyc(0, 0, 1, 1, 32'h00500093, 32'h100);
    check("t1_valid", out_valid, 1);
    check("t1_fmt", fmt, FMT_I);
    check("t1_rd", add_rd, 1);
    check("t1_imm", imm, 32'h5);
    check("t1_en", {rd_we, rs2_en}, 2'b10);
    cyc(0, 0, 1, 1, 32'hFE20AE23, 32'h104);
    check("t2_fmt", fmt, FMT_S);
    check("t2_rs", {add_rs1, add_rs2}, {5'd1, 5'd2});
    check("t2_imm", imm, 32'hFFFFFFFC);
    check("t2_we", rd_we, 0);
    cyc(0, 0, 1, 1, 32'h123452B7, 32'h108);
    check("t3_lui_imm", imm, 32'h12345000);
    cyc(0, 0, 1, 1, 32'h008000EF, 32'h10C);
    check("t3_jal_fmt", fmt, FMT_J);
    check("t3_jal_imm", imm, 32'h8);
    check("t3_jal_we", rd_we, 1);
    cyc(0, 0, 0, 1, 0, 0);

    // illegal counting and saturation
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h0, 32'h200);
    check("t4_ill", illegal, 1);
    check("t4_fmt", fmt, FMT_X);
    check("t4_en", {rs1_en, rs2_en, rd_we}, 0);
    check("t4_cnt0", illegal_cnt, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("t4_cnt1", illegal_cnt, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 32'h0, 32'h204 + 4 * k);
    cyc(0, 0, 0, 1, 0, 0);
    check("t4_sat", illegal_cnt, 3);

    // backpressure
    cyc(0, 0, 1, 0, 32'h00A00113, 32'h300);
    cyc(0, 0, 1, 0, 32'h00B00193, 32'h304);
    check("t5_stall_rdy", last_in_ready, 0);
    check("t5_held_pc", pc_out, 32'h300);
    cyc(0, 0, 1, 1, 32'h00B00193, 32'h304);
    check("t5_drain_rdy", last_in_ready, 1);
    check("t5_second_pc", pc_out, 32'h304);
    check("t5_valid", out_valid, 1);
    cyc(0, 0, 0, 1, 0, 0);
    check("t5_empty", out_valid, 0);

    // flush, flushed illegal not counted, reset mid-stream
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'hFFFFFFFF, 32'h400);
    cyc(0, 1, 1, 1, 32'h00500093, 32'h404);
    check("t6_flush_rdy", last_in_ready, 0);
    check("t6_flush_valid", out_valid, 0);
    check("t6_flush_cnt", illegal_cnt, 0);
    cyc(0, 0, 1, 1, 32'h00C00213, 32'h408);
    cyc(1, 0, 1, 1, 32'h0, 32'h40C);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_imm", imm, 0);
    check("t6_rst_cnt", illegal_cnt, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          rand_instr(), 32'h1000 + 32'(n) * 4);
    end
    cyc(0, 0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
